// File: rtl/jam_cost_loader.sv
// Purpose: loads an NxN cost matrix for the JAM engine, releases the engine, serves
//          its cost lookups, then captures its MinCost/MatchCount result.
// Latency: in_ready rises 1 cycle after start. Cost is combinational. The result is registered on the jam_valid edge.
// Backpressure: words move on in_valid&in_ready. The result is held in res_valid until res_ack.
//
// Ports:
//   CLK, RST                      clock, async active-high reset
//   start                         pulse in IDLE to begin a load/run job
//   in_valid/in_ready/in_data/in_last   row-major cost word stream (worker-major)
//   jam_rst                       engine reset, low only while the engine runs
//   W, J -> Cost                  engine cost lookup, zero outside RUN
//   jam_valid/jam_mincost/jam_matchcount   engine result strobe
//   res_valid/res_ack/res_mincost/res_matchcount   captured result handshake
//   err                           last job aborted (bad framing or watchdog), sticky to next start
module jam_cost_loader #(
    parameter int N       = 8,
    parameter int CW      = 7,
    parameter int SW      = 10,
    parameter int TO_W    = 19,
    parameter int TIMEOUT = 500000
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_data,
    input  logic          in_last,
    output logic          jam_rst,
    input  logic [2:0]    W,
    input  logic [2:0]    J,
    output logic [CW-1:0] Cost,
    input  logic          jam_valid,
    input  logic [SW-1:0] jam_mincost,
    input  logic [3:0]    jam_matchcount,
    output logic          res_valid,
    input  logic          res_ack,
    output logic [SW-1:0] res_mincost,
    output logic [3:0]    res_matchcount,
    output logic          err
);

    localparam int AW = $clog2(N*N);
    localparam logic [AW-1:0]   LAST_IDX = AW'(N*N-1);
    localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT-1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic [TO_W-1:0] wd;
    logic [CW-1:0] mem [N*N];

    logic job_start;   // accepted start: clears counter and err
    logic accept;      // a load word is written this cycle
    logic err_set;     // framing error or watchdog expiry
    logic capture;     // engine result captured this cycle
    logic ack_done;    // result consumed

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_nxt = state;
        job_start = 1'b0;
        accept    = 1'b0;
        err_set   = 1'b0;
        capture   = 1'b0;
        ack_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    job_start = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid && in_ready) begin
                    accept = 1'b1;
                    if (cnt == LAST_IDX) begin
                        // The final word must carry in_last. Otherwise the frame is too long.
                        if (in_last) begin
                            state_nxt = S_RUN;
                        end else begin
                            err_set   = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end else if (in_last) begin
                        // The frame is short. The word is still written, but the job is aborted.
                        err_set   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                // A result arriving on the expiry cycle takes priority over the abort.
                if (jam_valid) begin
                    capture   = 1'b1;
                    state_nxt = S_DONE;
                end else if (wd == WD_LIMIT) begin
                    err_set   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                if (res_ack) begin
                    ack_done  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs and datapath state. in_ready and jam_rst come from the
    // next state, so they change on the same edge as the state itself.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            in_ready       <= 1'b0;
            jam_rst        <= 1'b1;
            res_valid      <= 1'b0;
            res_mincost    <= '0;
            res_matchcount <= '0;
            err            <= 1'b0;
            cnt            <= '0;
            wd             <= '0;
        end else begin
            in_ready <= (state_nxt == S_LOAD);
            jam_rst  <= (state_nxt != S_RUN);

            if (job_start) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + AW'(1);
            end

            // The count restarts at zero on every RUN entry because RUN is always
            // preceded by at least one non-RUN cycle.
            if (state == S_RUN) begin
                wd <= wd + TO_W'(1);
            end else begin
                wd <= '0;
            end

            if (job_start) begin
                err <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end

            if (capture) begin
                res_valid      <= 1'b1;
                res_mincost    <= jam_mincost;
                res_matchcount <= jam_matchcount;
            end else if (ack_done) begin
                res_valid <= 1'b0;
            end
        end
    end

    // Matrix storage. It has no reset; contents are only meaningful after a complete load.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[cnt] <= in_data;
        end
    end

    assign Cost = (state == S_RUN) ? mem[{W, J}] : '0;

endmodule

// File: tb/tb_jam_cost_loader.sv
module tb_jam_cost_loader;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_data;
    logic       in_last;
    logic       jam_rst;
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost;
    logic       jam_valid;
    logic [9:0] jam_mincost;
    logic [3:0] jam_matchcount;
    logic       res_valid;
    logic       res_ack;
    logic [9:0] res_mincost;
    logic [3:0] res_matchcount;
    logic       err;

    int nchk = 0;
    int nerr = 0;
    int model [64];   // intended matrix contents, row-major w*8+j

    typedef struct {
        logic [2:0] w;
        logic [2:0] j;
        logic [6:0] cost;
    } vec_t;
    vec_t tbl [6];

    always #5 CLK = ~CLK;

    jam_cost_loader #(.TIMEOUT(100)) dut (
        .CLK(CLK), .RST(RST), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .jam_rst(jam_rst), .W(W), .J(J), .Cost(Cost),
        .jam_valid(jam_valid), .jam_mincost(jam_mincost), .jam_matchcount(jam_matchcount),
        .res_valid(res_valid), .res_ack(res_ack),
        .res_mincost(res_mincost), .res_matchcount(res_matchcount), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic void fill_diag();
        for (int i = 0; i < 64; i++) model[i] = ((i / 8) == (i % 8)) ? 1 : 10;
    endfunction

    function automatic void fill_rand();
        for (int i = 0; i < 64; i++) model[i] = $urandom_range(1, 127);
    endfunction

    // Reference minimum: the sum of the row minima. It equals the optimum for the
    // diagonal matrix and serves as the engine stub's reported value.
    function automatic int rowmin_sum();
        int s;
        int m;
        s = 0;
        for (int w = 0; w < 8; w++) begin
            m = 1000;
            for (int j = 0; j < 8; j++) if (model[w*8+j] < m) m = model[w*8+j];
            s += m;
        end
        return s;
    endfunction

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Streams up to nwords words. in_last is set on word last_at (-1 = never).
    // mode 0: in_valid always high; 1: toggles each cycle; 2: random.
    task automatic load(input int last_at, input int nwords, input int mode, output int writes);
        int  idx;
        int  cyc;
        bit  ph;
        bit  acc;
        idx = 0; cyc = 0; ph = 1'b1; writes = 0;
        while (idx < nwords && cyc < 600) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = ph;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            ph      = !ph;
            in_data = 7'(model[idx]);
            in_last = (idx == last_at);
            acc     = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) begin
                idx++;
                writes++;
                if (idx - 1 == last_at) break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Engine stub: reads every cost, then reports a result on RUN cycle 64.
    task automatic run_engine(input logic [3:0] mc, input int exp_min);
        chk("jam_rst_low_in_run", jam_rst, 1'b0);
        for (int i = 0; i < 64; i++) begin
            W = 3'(i / 8);
            J = 3'(i % 8);
            #1;
            chk("cost_sweep", Cost, model[i]);
            tick();
        end
        jam_valid      = 1'b1;
        jam_mincost    = 10'(exp_min);
        jam_matchcount = mc;
        tick();
        jam_valid = 1'b0;
        chk("res_valid_set", res_valid, 1'b1);
        chk("res_mincost", res_mincost, exp_min);
        chk("res_matchcount", res_matchcount, mc);
        chk("jam_rst_after_valid", jam_rst, 1'b1);
        chk("err_after_valid", err, 1'b0);
        chk("cost_zero_done", Cost, 0);
    endtask

    task automatic ack_result();
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        chk("res_valid_cleared", res_valid, 1'b0);
    endtask

    initial begin
        int wr;
        int emin;
        logic [3:0] mc;

        tbl[0] = '{3'd5, 3'd3, 7'd10};
        tbl[1] = '{3'd4, 3'd4, 7'd1};
        tbl[2] = '{3'd0, 3'd0, 7'd1};
        tbl[3] = '{3'd7, 3'd0, 7'd10};
        tbl[4] = '{3'd7, 3'd7, 7'd1};
        tbl[5] = '{3'd0, 3'd7, 7'd10};

        RST = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        W = '0; J = '0; jam_valid = 1'b0; jam_mincost = '0; jam_matchcount = '0; res_ack = 1'b0;
        tick(); tick();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_jam_rst", jam_rst, 1'b1);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_mincost", res_mincost, 0);
        chk("rst_res_matchcount", res_matchcount, 0);
        chk("rst_err", err, 1'b0);
        chk("rst_cost", Cost, 0);
        RST = 1'b0;
        tick();

        // Diagonal matrix, full load, result and ack
        fill_diag();
        chk("in_ready_idle", in_ready, 1'b0);
        do_start();
        chk("in_ready_rise", in_ready, 1'b1);
        load(63, 64, 0, wr);
        chk("load_words", wr, 64);
        chk("in_ready_fall", in_ready, 1'b0);
        chk("jam_rst_release", jam_rst, 1'b0);
        emin = rowmin_sum();
        chk("diag_expected_min", emin, 8);
        run_engine(4'd1, emin);
        ack_result();
        tick();
        chk("idle_after_ack", in_ready, 1'b0);

        // Backpressure: in_valid toggling, then table lookups
        do_start();
        load(63, 64, 1, wr);
        chk("bp_load_words", wr, 64);
        chk("bp_jam_rst", jam_rst, 1'b0);
        for (int k = 0; k < 6; k++) begin
            W = tbl[k].w;
            J = tbl[k].j;
            #1;
            chk("tbl_cost", Cost, tbl[k].cost);
            tick();
        end
        run_engine(4'd1, rowmin_sum());
        ack_result();

        // Early in_last on word 20
        fill_rand();
        do_start();
        load(20, 64, 0, wr);
        chk("short_words", wr, 21);
        chk("short_err", err, 1'b1);
        chk("short_in_ready", in_ready, 1'b0);
        chk("short_jam_rst", jam_rst, 1'b1);
        chk("short_res_valid", res_valid, 1'b0);
        tick();
        chk("short_jam_rst_hold", jam_rst, 1'b1);
        chk("short_err_sticky", err, 1'b1);
        do_start();
        chk("start_clears_err", err, 1'b0);

        // Word 63 without in_last
        load(-1, 64, 0, wr);
        chk("long_err", err, 1'b1);
        chk("long_in_ready", in_ready, 1'b0);
        chk("long_jam_rst", jam_rst, 1'b1);

        // Mid-load reset at word 30, then a full reload
        do_start();
        load(-1, 30, 0, wr);
        chk("mid_in_ready_before", in_ready, 1'b1);
        RST = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_jam_rst", jam_rst, 1'b1);
        chk("mid_rst_err", err, 1'b0);
        tick();
        RST = 1'b0;
        tick();
        fill_rand();
        do_start();
        load(63, 64, 0, wr);
        chk("reload_jam_rst", jam_rst, 1'b0);
        run_engine(4'd3, rowmin_sum());
        ack_result();

        // Watchdog expiry with no result
        fill_rand();
        do_start();
        load(63, 64, 0, wr);
        W = 3'd2; J = 3'd5;
        for (int c = 0; c < 99; c++) tick();
        chk("wd_jam_rst_cycle99", jam_rst, 1'b0);
        chk("wd_err_cycle99", err, 1'b0);
        tick();
        chk("wd_jam_rst", jam_rst, 1'b1);
        chk("wd_err", err, 1'b1);
        chk("wd_cost_zero", Cost, 0);
        chk("wd_res_valid", res_valid, 1'b0);

        // Result on the expiry cycle wins
        do_start();
        load(63, 64, 0, wr);
        for (int c = 0; c < 99; c++) tick();
        emin = rowmin_sum();
        jam_valid = 1'b1; jam_mincost = 10'(emin); jam_matchcount = 4'd7;
        tick();
        jam_valid = 1'b0;
        chk("race_res_valid", res_valid, 1'b1);
        chk("race_err", err, 1'b0);
        chk("race_mincost", res_mincost, emin);
        chk("race_jam_rst", jam_rst, 1'b1);

        // DONE: start without ack has no effect
        do_start();
        chk("done_start_res_valid", res_valid, 1'b1);
        chk("done_start_mincost", res_mincost, emin);
        chk("done_start_matchcount", res_matchcount, 7);
        chk("done_start_in_ready", in_ready, 1'b0);
        // start with ack: goes to IDLE, no load begins
        start = 1'b1; res_ack = 1'b1;
        tick();
        start = 1'b0; res_ack = 1'b0;
        chk("ack_start_res_valid", res_valid, 1'b0);
        chk("ack_start_in_ready", in_ready, 1'b0);
        tick();
        chk("ack_start_no_load", in_ready, 1'b0);
        chk("held_mincost", res_mincost, emin);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        chk("stray_ack", res_valid, 1'b0);

        // Randomized jobs
        for (int it = 0; it < 4; it++) begin
            int dly;
            fill_rand();
            do_start();
            load(63, 64, 2, wr);
            chk("rnd_load_words", wr, 64);
            mc = 4'($urandom_range(0, 15));
            emin = rowmin_sum();
            run_engine(mc, emin);
            dly = $urandom_range(0, 5);
            for (int d = 0; d < dly; d++) tick();
            chk("rnd_res_hold", res_valid, 1'b1);
            chk("rnd_mincost_hold", res_mincost, emin);
            ack_result();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        nerr++;
        nchk++;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
